polyvec_frombytes_masked: RTL and testbench
===========================================

POLYVEC_FROMBYTES_MASKED -- requirements
Module: polyvec_frombytes_masked

Interface
REQ-001 SHALL have parameter KYBER_K, default 2, number of polynomials in the vector.
REQ-002 SHALL have parameter KYBER_N, default 256, coefficients per polynomial.
REQ-003 SHALL have parameter KYBER_Q, default 3329, modulus.
REQ-004 SHALL have parameter LANES, default 8, coefficients per output beat; must be even and divide KYBER_N.
REQ-005 SHALL have parameter COEFF_SZ, default 16, output share lane width.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port enable  input  1  start request, sampled in IDLE only.
REQ-009 SHALL have port clear  input  1  synchronous abort, returns to IDLE.
REQ-010 SHALL have port i_polyvec  input  12*KYBER_N*KYBER_K  packed byte vector; coefficient i of poly k at bits [k*12*KYBER_N+12*i +: 12].
REQ-011 SHALL have port PRNG_data  input  16*LANES  fresh randomness, lane j at [16*j +: 16].
REQ-012 SHALL have port o_ready  input  1  downstream accepts current beat.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port out_valid  output  1  o_poly_s1/o_poly_s2 hold a valid beat.
REQ-015 SHALL have port o_poly_s1  output  COEFF_SZ*LANES  share 1, lane j at [COEFF_SZ*j +: COEFF_SZ].
REQ-016 SHALL have port o_poly_s2  output  COEFF_SZ*LANES  share 2, same layout.
REQ-017 SHALL have port o_poly_idx  output  clog2(KYBER_K)+1  polynomial index of current beat.
REQ-018 SHALL have port o_coeff_idx  output  clog2(KYBER_N)  index of lane 0 coefficient in current beat.
REQ-019 SHALL have port Function_Done  output  1  one-cycle pulse after final beat accepted.

Function
REQ-020 SHALL implement states IDLE, LOAD, MASK, OUT; beat counter b runs 0..BEATS-1, BEATS = KYBER_K*KYBER_N/LANES.
REQ-021 IDLE: enable=1 -> LOAD with b=0, busy=1 next cycle; enable=0 -> stay.
REQ-022 LOAD: register LANES 12-bit coefficients of beat b (poly b/(KYBER_N/LANES), start coefficient (b*LANES) mod KYBER_N) into c[j], each reduced: c>=KYBER_Q -> c-KYBER_Q (one subtraction); -> MASK.
REQ-023 MASK: r[j] = PRNG_data lane j bits [11:0], reduced identically; o_poly_s1 lane j <= r[j]; o_poly_s2 lane j <= (c[j]-r[j]) mod KYBER_Q, in [0,KYBER_Q-1], zero-extended to COEFF_SZ; set o_poly_idx/o_coeff_idx; -> OUT with out_valid=1.
REQ-024 OUT: out_valid=1, outputs stable while o_ready=0; out_valid&&o_ready with b<BEATS-1 -> LOAD, b<=b+1, out_valid<=0.
REQ-025 OUT handshake at b=BEATS-1 -> IDLE; next cycle Function_Done=1 for exactly one cycle, busy=0, out_valid=0.
REQ-026 First out_valid SHALL rise 3 cycles after the enable-sampling edge; subsequent beats at most one every 3 cycles.
REQ-027 enable while busy SHALL be ignored; i_polyvec SHALL be held stable by the source while busy.
REQ-028 PRNG_data SHALL be sampled only in MASK; each beat uses the value present in that cycle.
REQ-029 clear=1 in any state SHALL force IDLE, b=0, out_valid=0, no Function_Done pulse; clear has priority over enable and o_ready.
REQ-030 Shares SHALL satisfy (s1+s2) mod KYBER_Q = reduced coefficient for every lane.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE, b=0, busy=0, out_valid=0, Function_Done=0, o_poly_s1=0, o_poly_s2=0, o_poly_idx=0, o_coeff_idx=0.
REQ-032 Reset mid-operation SHALL abandon the vector; after release, a new enable restarts from beat 0.

Verification
REQ-033 All-zero i_polyvec, PRNG_data=0, o_ready=1, defaults -> 64 beats, all shares 0, o_poly_idx 0 for beats 0-31 and 1 for 32-63, Function_Done one cycle after 64th handshake.
REQ-034 Coefficient 0xFFF, PRNG lane 0x005 -> s1=5, s2=761; coefficient 0, PRNG lane 0x001 -> s1=1, s2=3328.
REQ-035 PRNG lane 0xFFF, coefficient 1000 -> s1=766, s2=234.
REQ-036 o_ready held 0 for 10 cycles in OUT -> out_valid stays 1, shares and indices unchanged, b does not advance.
REQ-037 resetn pulsed low at beat 10 -> all outputs 0 immediately; clear=1 at beat 10 -> IDLE next cycle, no Function_Done; new enable -> o_coeff_idx=0, o_poly_idx=0.
REQ-038 enable pulsed during OUT -> no restart; beat sequence and Function_Done unaffected.

Source files
------------

// File: rtl/polyvec_frombytes_masked.sv
// polyvec_frombytes_masked
//   Streams a packed Kyber polynomial vector out as Boolean-free arithmetic
//   shares: each 12-bit coefficient c is reduced once mod q and split into
//   (s1, s2) with s1 = fresh random r (reduced) and s2 = (c - r) mod q, so
//   (s1 + s2) mod q == c. One beat carries LANES coefficients.
//   Per beat the FSM walks LOAD -> MASK -> OUT, so beats are at least
//   3 cycles apart.
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   enable             start request (only looked at in IDLE)
//   clear              synchronous abort back to IDLE, beats the other inputs
//   i_polyvec          packed 12-bit coefficients, poly-major
//   PRNG_data          16 bits of randomness per lane, low 12 bits used
//   o_ready            downstream accepts the presented beat
//   busy               FSM not in IDLE
//   out_valid          o_poly_s1/o_poly_s2 hold a beat
//   o_poly_s1/s2       share lanes, COEFF_SZ bits each
//   o_poly_idx         polynomial index of the presented beat
//   o_coeff_idx        coefficient index of lane 0 of the presented beat
//   Function_Done      one-cycle pulse after the final beat is accepted

module pfm_lane #(
    parameter int KYBER_Q  = 3329,
    parameter int COEFF_SZ = 16
) (
    input  logic [11:0]         raw_i,
    input  logic [11:0]         c_i,
    input  logic [11:0]         rnd_i,
    output logic [11:0]         c_red_o,
    output logic [COEFF_SZ-1:0] s1_o,
    output logic [COEFF_SZ-1:0] s2_o
);
    logic [11:0] r_red;
    logic [12:0] diff;

    // Inputs never exceed 4095 < 2q, so one conditional subtraction reduces.
    assign c_red_o = (raw_i >= 12'(KYBER_Q)) ? raw_i - 12'(KYBER_Q) : raw_i;
    assign r_red   = (rnd_i >= 12'(KYBER_Q)) ? rnd_i - 12'(KYBER_Q) : rnd_i;

    // c - r lies in (-q, q); adding q once when negative lands in [0, q-1].
    assign diff = (c_i >= r_red) ? {1'b0, c_i} - {1'b0, r_red}
                                 : {1'b0, c_i} + 13'(KYBER_Q) - {1'b0, r_red};

    assign s1_o = COEFF_SZ'(r_red);
    assign s2_o = COEFF_SZ'(diff);
endmodule

module polyvec_frombytes_masked #(
    parameter int KYBER_K  = 2,
    parameter int KYBER_N  = 256,
    parameter int KYBER_Q  = 3329,
    parameter int LANES    = 8,
    parameter int COEFF_SZ = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [12*KYBER_N*KYBER_K-1:0] i_polyvec,
    input  logic [16*LANES-1:0]           PRNG_data,
    input  logic                          o_ready,
    output logic                          busy,
    output logic                          out_valid,
    output logic [COEFF_SZ*LANES-1:0]     o_poly_s1,
    output logic [COEFF_SZ*LANES-1:0]     o_poly_s2,
    output logic [$clog2(KYBER_K):0]      o_poly_idx,
    output logic [$clog2(KYBER_N)-1:0]    o_coeff_idx,
    output logic                          Function_Done
);
    localparam int PW = $clog2(KYBER_K) + 1;
    localparam int CW = $clog2(KYBER_N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MASK, S_OUT} state_t;

    state_t  state_q, state_d;
    // Beat counter kept as (polynomial, start coefficient) so no divider is needed.
    logic [PW-1:0] poly_q, poly_d;
    logic [CW-1:0] cidx_q, cidx_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic          load_en, mask_en, last_beat;

    logic [LANES-1:0][11:0]         raw, c_red, c_q;
    logic [LANES-1:0][COEFF_SZ-1:0] s1, s2, s1_q, s2_q;
    logic [PW-1:0]                  pidx_q;
    logic [CW-1:0]                  coidx_q;
    int                             base;
    logic                           prng_unused;

    assign prng_unused = ^PRNG_data;
    assign base        = int'(poly_q) * 12 * KYBER_N + 12 * int'(cidx_q);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign raw[j] = i_polyvec[base + 12*j +: 12];
        pfm_lane #(.KYBER_Q(KYBER_Q), .COEFF_SZ(COEFF_SZ)) u_lane (
            .raw_i   (raw[j]),
            .c_i     (c_q[j]),
            .rnd_i   (PRNG_data[16*j +: 12]),
            .c_red_o (c_red[j]),
            .s1_o    (s1[j]),
            .s2_o    (s2[j])
        );
    end

    assign last_beat = (poly_q == PW'(KYBER_K - 1)) && (cidx_q == CW'(KYBER_N - LANES));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            poly_q  <= '0;
            cidx_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            poly_q  <= poly_d;
            cidx_q  <= cidx_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        poly_d  = poly_q;
        cidx_d  = cidx_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        load_en = 1'b0;
        mask_en = 1'b0;
        case (state_q)
            S_IDLE: if (enable) begin
                state_d = S_LOAD;
                poly_d  = '0;
                cidx_d  = '0;
            end
            S_LOAD: begin
                load_en = 1'b1;
                state_d = S_MASK;
            end
            S_MASK: begin
                mask_en = 1'b1;
                vld_d   = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: if (o_ready) begin
                vld_d = 1'b0;
                if (last_beat) begin
                    state_d = S_IDLE;
                    poly_d  = '0;
                    cidx_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    if (cidx_q == CW'(KYBER_N - LANES)) begin
                        cidx_d = '0;
                        poly_d = poly_q + 1'b1;
                    end else begin
                        cidx_d = cidx_q + CW'(LANES);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            poly_d  = '0;
            cidx_d  = '0;
            vld_d   = 1'b0;
            done_d  = 1'b0;
            load_en = 1'b0;
            mask_en = 1'b0;
        end
    end

    // Datapath: reduced coefficients captured in LOAD, shares and indices in MASK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_q     <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            pidx_q  <= '0;
            coidx_q <= '0;
        end else begin
            if (load_en) c_q <= c_red;
            if (mask_en) begin
                s1_q    <= s1;
                s2_q    <= s2;
                pidx_q  <= poly_q;
                coidx_q <= cidx_q;
            end
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign out_valid     = vld_q;
    assign Function_Done = done_q;
    assign o_poly_s1     = s1_q;
    assign o_poly_s2     = s2_q;
    assign o_poly_idx    = pidx_q;
    assign o_coeff_idx   = coidx_q;
endmodule

// File: tb/tb_polyvec_frombytes_masked.sv
module tb_polyvec_frombytes_masked;
    localparam int K = 2, N = 256, L = 8, Q = 3329, CSZ = 16;
    localparam int BEATS = K * N / L;
    localparam int PVW = 12 * N * K;

    logic                 clk = 1'b0;
    logic                 resetn, enable, clear, o_ready;
    logic [PVW-1:0]       i_polyvec;
    logic [16*L-1:0]      PRNG_data;
    logic                 busy, out_valid, Function_Done;
    logic [CSZ*L-1:0]     o_poly_s1, o_poly_s2;
    logic [$clog2(K):0]   o_poly_idx;
    logic [$clog2(N)-1:0] o_coeff_idx;

    polyvec_frombytes_masked dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
        .i_polyvec(i_polyvec), .PRNG_data(PRNG_data), .o_ready(o_ready),
        .busy(busy), .out_valid(out_valid), .o_poly_s1(o_poly_s1),
        .o_poly_s2(o_poly_s2), .o_poly_idx(o_poly_idx),
        .o_coeff_idx(o_coeff_idx), .Function_Done(Function_Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CSZ*L-1:0] s1;
        logic [CSZ*L-1:0] s2;
        int               pidx;
        int               cidx;
        bit               last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_chk = 0, n_fail = 0, hs_cnt = 0, done_cnt = 0;
    bit    done_exp = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int red(input int x);
        return (x >= Q) ? x - Q : x;
    endfunction

    // Expected beats for a full vector; hand values for lanes 0-2 of beat 0.
    task automatic push_run(input logic [PVW-1:0] pv, input logic [16*L-1:0] prng, input bit hand);
        beat_t e;
        for (int b = 0; b < BEATS; b++) begin
            e.pidx = b / (N / L);
            e.cidx = (b * L) % N;
            e.last = (b == BEATS - 1);
            for (int j = 0; j < L; j++) begin
                int c, r;
                c = red(int'(pv[(e.pidx * N + e.cidx + j) * 12 +: 12]));
                r = red(int'(prng[16 * j +: 12]));
                e.s1[CSZ * j +: CSZ] = CSZ'(r);
                e.s2[CSZ * j +: CSZ] = CSZ'((c - r + Q) % Q);
            end
            if (hand && b == 0) begin
                e.s1[0 +: CSZ]  = 16'd5;   e.s2[0 +: CSZ]  = 16'd761;
                e.s1[16 +: CSZ] = 16'd1;   e.s2[16 +: CSZ] = 16'd3328;
                e.s1[32 +: CSZ] = 16'd766; e.s2[32 +: CSZ] = 16'd234;
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (done_exp) begin
            chk("done_pulse", Function_Done, 1);
            chk("done_busy", busy, 0);
            chk("done_valid", out_valid, 0);
            done_exp = 1'b0;
        end else begin
            chk("done_spurious", Function_Done, 0);
        end
        if (Function_Done) done_cnt++;
        if (out_valid && o_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat act=beat%0d exp=none", hs_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                chk("s1", o_poly_s1, mon_e.s1);
                chk("s2", o_poly_s2, mon_e.s2);
                chk("poly_idx", o_poly_idx, mon_e.pidx);
                chk("coeff_idx", o_coeff_idx, mon_e.cidx);
                if (mon_e.last) done_exp = 1'b1;
            end
        end
    end

    task automatic start();
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_cnt < n && t < 1000) begin @(posedge clk); t++; end
        #1;
        if (hs_cnt < n) chk("hs_timeout", hs_cnt, n);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 3000) begin @(posedge clk); t++; end
        #1;
        if (done_cnt < n) chk("done_timeout", done_cnt, n);
    endtask

    logic [PVW-1:0]  pv1;
    logic [16*L-1:0] prng1, prng2;
    int              pr1[L] = '{'h005, 'h001, 'hFFF, 'hD00, 'hD01, 'hABC, 'h7FF, 'h000};

    initial begin
        resetn = 1'b0; enable = 1'b0; clear = 1'b0; o_ready = 1'b1;
        i_polyvec = '0; PRNG_data = '0;
        for (int i = 0; i < K * N; i++) pv1[i * 12 +: 12] = 12'((i * 1237 + 5) % 4096);
        pv1[0 +: 12] = 12'hFFF; pv1[12 +: 12] = 12'd0; pv1[24 +: 12] = 12'd1000;
        for (int j = 0; j < L; j++) begin
            prng1[16 * j +: 16] = 16'(pr1[j] | 'hA000);  // upper nibble must be ignored
            prng2[16 * j +: 16] = 16'((j * 'h1F3 + 'h0F0) & 'hFFFF);
        end

        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_s1", o_poly_s1, 0);
        chk("rst_s2", o_poly_s2, 0);
        chk("rst_pidx", o_poly_idx, 0);
        chk("rst_cidx", o_coeff_idx, 0);
        chk("rst_done", Function_Done, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // All-zero vector
        push_run('0, '0, 1'b0);
        start();
        wait_done(1);

        // Directed coefficients with backpressure on beat 5
        i_polyvec = pv1; PRNG_data = prng1;
        push_run(pv1, prng1, 1'b1);
        start();
        wait_hs(hs_cnt + 5);
        o_ready = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_s1", o_poly_s1, exp_q[0].s1);
            chk("hold_s2", o_poly_s2, exp_q[0].s2);
            chk("hold_pidx", o_poly_idx, exp_q[0].pidx);
            chk("hold_cidx", o_coeff_idx, exp_q[0].cidx);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
        wait_done(2);

        // Enable pulsed mid-run must not restart
        PRNG_data = prng2;
        push_run(pv1, prng2, 1'b0);
        start();
        wait_hs(hs_cnt + 20);
        enable = 1'b1;
        repeat (3) @(posedge clk); #1;
        enable = 1'b0;
        wait_done(3);

        // Asynchronous reset at beat 10
        PRNG_data = prng1;
        push_run(pv1, prng1, 1'b1);
        start();
        wait_hs(hs_cnt + 10);
        #1 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_s1", o_poly_s1, 0);
        chk("arst_s2", o_poly_s2, 0);
        chk("arst_pidx", o_poly_idx, 0);
        chk("arst_cidx", o_coeff_idx, 0);
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        push_run(pv1, prng1, 1'b1);
        start();
        wait_done(4);

        // Synchronous clear at beat 10
        PRNG_data = prng2;
        push_run(pv1, prng2, 1'b0);
        start();
        wait_hs(hs_cnt + 10);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        exp_q.delete();
        repeat (5) @(posedge clk); #1;
        push_run(pv1, prng2, 1'b0);
        start();
        wait_done(5);

        repeat (3) @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
